// File: rtl/neuron_feed_sequencer_if.sv
// rtl/neuron_feed_sequencer_if.sv - pixel/weight memory read port and neuron calculator drive bus
interface neuron_feed_sequencer_if #(
  parameter int DATA_WIDTH       = 24,
  parameter int ADDR_DEPTH       = 12,
  parameter int WEIGHT_PRECISION = 5
);
  logic                          rd_en;
  logic [ADDR_DEPTH-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0]         pix_data;
  logic [3*WEIGHT_PRECISION-1:0] wgt_data;
  logic [DATA_WIDTH-1:0]         x;
  logic [3*WEIGHT_PRECISION-1:0] w;
  logic [DATA_WIDTH-1:0]         b;
  logic                          enable;
  logic                          get_result;
  logic                          neuron_out;

  modport master (
    output rd_en, rd_addr, x, w, b, enable, get_result,
    input  pix_data, wgt_data, neuron_out
  );

  modport slave (
    input  rd_en, rd_addr, x, w, b, enable, get_result,
    output pix_data, wgt_data, neuron_out
  );
endinterface

// File: rtl/neuron_feed_sequencer.sv
// rtl/neuron_feed_sequencer.sv - streams one image into the neuron calculator and captures its decision (SEQ_ABORT_EN adds abort_i)
module neuron_feed_sequencer #(
  parameter int DATA_WIDTH       = 24,
  parameter int ADDR_DEPTH       = 12,
  parameter int WEIGHT_PRECISION = 5,
  parameter int NUM_WORDS        = 4096,
  parameter int MEM_LATENCY      = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] bias_in_i,
`ifdef SEQ_ABORT_EN
  input  logic                  abort_i,
`endif
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  is_cat_o,
  neuron_feed_sequencer_if.master bus
);

  localparam int WW = 3 * WEIGHT_PRECISION;
  localparam logic [ADDR_DEPTH-1:0] LAST_ADDR = ADDR_DEPTH'(NUM_WORDS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_RESULT  = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
`ifdef SEQ_ABORT_EN
  localparam logic [2:0] S_ABORT   = 3'd5;
`endif

  logic [2:0]             state_q, state_d;
  logic                   rd_en_q, rd_en_d;
  logic [ADDR_DEPTH-1:0]  rd_addr_q, rd_addr_d;
  logic [MEM_LATENCY-1:0] vpipe_q, vpipe_d;
  logic [DATA_WIDTH-1:0]  x_q, x_d;
  logic [WW-1:0]          w_q, w_d;
  logic [DATA_WIDTH-1:0]  b_q, b_d;
  logic                   enable_q, enable_d;
  logic                   get_result_q, get_result_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   is_cat_q, is_cat_d;

  // Next-state: read sequencing, valid pipe tracking memory latency, calculator strobes
  always_comb begin
    state_d      = state_q;
    rd_en_d      = rd_en_q;
    rd_addr_d    = rd_addr_q;
    vpipe_d      = (vpipe_q << 1) | MEM_LATENCY'(rd_en_q);
    x_d          = x_q;
    w_d          = w_q;
    b_d          = b_q;
    enable_d     = 1'b0;
    get_result_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    is_cat_d     = is_cat_q;

    // Oldest pipe stage marks the cycle its read data is on the memory bus
    if (vpipe_q[MEM_LATENCY-1]) begin
      x_d      = bus.pix_data;
      w_d      = bus.wgt_data;
      enable_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        rd_en_d   = 1'b0;
        rd_addr_d = '0;
        // busy still high here means this is the done cycle; start waits one more cycle
        if (busy_q) begin
          busy_d = 1'b0;
        end else if (start_i) begin
          state_d = S_FETCH;
          busy_d  = 1'b1;
          b_d     = bias_in_i;
          rd_en_d = 1'b1;
        end
      end
      S_FETCH: begin
        if (rd_addr_q == LAST_ADDR) begin
          rd_en_d   = 1'b0;
          rd_addr_d = '0;
          state_d   = S_DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (vpipe_q == '0) begin
          state_d      = S_RESULT;
          get_result_d = 1'b1;
        end
      end
      S_RESULT: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_d  = S_IDLE;
        is_cat_d = bus.neuron_out;
        done_d   = 1'b1;
      end
`ifdef SEQ_ABORT_EN
      S_ABORT: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef SEQ_ABORT_EN
    // Abort flushes in-flight reads and clears the calculator accumulator without a done
    if (abort_i && (state_q == S_FETCH || state_q == S_DRAIN)) begin
      state_d      = S_ABORT;
      rd_en_d      = 1'b0;
      rd_addr_d    = '0;
      vpipe_d      = '0;
      enable_d     = 1'b0;
      get_result_d = 1'b1;
      x_d          = x_q;
      w_d          = w_q;
    end
`endif
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      vpipe_q      <= '0;
      x_q          <= '0;
      w_q          <= '0;
      b_q          <= '0;
      enable_q     <= 1'b0;
      get_result_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      is_cat_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      vpipe_q      <= vpipe_d;
      x_q          <= x_d;
      w_q          <= w_d;
      b_q          <= b_d;
      enable_q     <= enable_d;
      get_result_q <= get_result_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      is_cat_q     <= is_cat_d;
    end
  end

  assign bus.rd_en      = rd_en_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.x          = x_q;
  assign bus.w          = w_q;
  assign bus.b          = b_q;
  assign bus.enable     = enable_q;
  assign bus.get_result = get_result_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign is_cat_o       = is_cat_q;

endmodule
